// File: rtl/icache_refill_pkg.sv
//------------------------------------------------------------------------------
// Module   : icache_refill_pkg
// Purpose  : Shared geometry, AXI encodings and FSM state codes for the
//            instruction-cache refill engine.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package icache_refill_pkg;

  // Default line geometry: 32-bit words, 4 words per line, 16-byte lines.
  localparam int DEF_WORD       = 32;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_OFFSET_W   = 4;

  // AXI read-address encodings used by every refill burst.
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Refill FSM state codes.
  typedef logic [1:0] state_t;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/icache_refill_if.sv
//------------------------------------------------------------------------------
// Module   : icache_refill_if
// Purpose  : Bundles the ICache request/response handshake and the AXI-style
//            read address/data channels seen by the refill engine.
// Ports    : req_valid/req_addr/req_ready/line_data  - ICache side
//            ar_valid/ar_ready/ar_addr/ar_len/ar_size/ar_burst - read address
//            r_valid/r_ready/r_data/r_last            - read data
// Modports : slave  - the refill engine
//            master - the environment (ICache + memory)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface icache_refill_if
  import icache_refill_pkg::*;
#(
  parameter int WORD       = DEF_WORD,
  parameter int LINE_WORDS = DEF_LINE_WORDS
);

  logic                       req_valid;
  logic [WORD-1:0]            req_addr;
  logic                       req_ready;
  logic [LINE_WORDS*WORD-1:0] line_data;

  logic                       ar_valid;
  logic                       ar_ready;
  logic [WORD-1:0]            ar_addr;
  logic [7:0]                 ar_len;
  logic [2:0]                 ar_size;
  logic [1:0]                 ar_burst;

  logic                       r_valid;
  logic                       r_ready;
  logic [WORD-1:0]            r_data;
  logic                       r_last;

  modport slave (
    input  req_valid, req_addr,
    output req_ready, line_data,
    output ar_valid, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_data, r_last,
    output r_ready
  );

  modport master (
    output req_valid, req_addr,
    input  req_ready, line_data,
    input  ar_valid, ar_addr, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_data, r_last,
    input  r_ready
  );

endinterface

`default_nettype wire

// File: rtl/icache_refill.sv
//------------------------------------------------------------------------------
// Module   : icache_refill
// Purpose  : On an ICache miss, issues one line-aligned INCR burst read and
//            assembles the returned beats into a cache line, then presents
//            it with a single-cycle req_ready pulse.
// Ports    : clk  - system clock, rising edge
//            rst  - synchronous, active-low reset
//            bus  - icache_refill_if.slave (request + AXI read channels)
//            err  - sticky flag: r_last did not match the expected final beat
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int WORD       = DEF_WORD,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int OFFSET_W   = DEF_OFFSET_W
) (
  input  logic              clk,
  input  logic              rst,
  icache_refill_if.slave    bus,
  output logic              err
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] C_LAST_BEAT  = CNT_W'(LINE_WORDS - 1);
  // Clears the byte-offset bits so the burst starts at word 0 of the line.
  localparam logic [WORD-1:0]  C_ALIGN_MASK = ~WORD'((1 << OFFSET_W) - 1);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [WORD-1:0]        r_ar_addr;
  logic                   r_err;
  logic [WORD-1:0]        r_line [LINE_WORDS];

  logic                   w_beat;
  logic                   w_last_beat;

  assign w_beat      = (r_state == DATA) && bus.r_valid;
  assign w_last_beat = (r_cnt == C_LAST_BEAT);

  // Handshakes are pure decodes of the state register.
  assign bus.ar_valid  = (r_state == ADDR);
  assign bus.r_ready   = (r_state == DATA);
  // A request dropped mid-refill gets no completion pulse.
  assign bus.req_ready = (r_state == DONE) && bus.req_valid;

  assign bus.ar_addr   = r_ar_addr;
  assign bus.ar_len    = 8'(LINE_WORDS - 1);
  assign bus.ar_size   = AXI_SIZE_4B;
  assign bus.ar_burst  = AXI_BURST_INCR;
  assign err           = r_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ar_addr <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_ar_addr <= bus.req_addr & C_ALIGN_MASK;
            r_cnt     <= '0;
            r_state   <= ADDR;
          end
        end
        ADDR: begin
          if (bus.ar_ready) begin
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_beat) begin
            r_cnt <= r_cnt + CNT_W'(1);
            // Beat count, not r_last, decides completion.
            if (w_last_beat) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      // r_last must be high exactly on the final beat; anything else sticks.
      if (w_beat && (bus.r_last != w_last_beat)) begin
        r_err <= 1'b1;
      end
    end
  end

  // Line buffer: each word register is enabled by its decoded beat index.
  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_line_word
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_line[gi] <= '0;
        end else if (w_beat && (r_cnt == CNT_W'(gi))) begin
          r_line[gi] <= bus.r_data;
        end
      end
      assign bus.line_data[gi*WORD +: WORD] = r_line[gi];
    end
  endgenerate

endmodule

`default_nettype wire

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Memory-side refill engine directly downstream of the instruction cache controller.
- When the ICache misses, it raises memory_valid while held in its LOAD state. This block then issues one line-aligned incrementing burst read on the AXI-style read channel and assembles the returned beats into a full cache line.
- It presents the assembled line with a one-cycle ready pulse, which the ICache consumes in its WRITE state.

Parameters:
- WORD, 32, data/address word width in bits
- LINE_WORDS, 4, words per cache line; power of 2, range 2..16
- OFFSET_W, 4, byte-offset bits of a line (log2(LINE_WORDS*4))

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-low reset
- req_valid  in  1  refill request from the ICache (memory_valid); held high until req_ready
- req_addr  in  WORD  miss address; any byte offset allowed
- req_ready  out  1  one-cycle pulse: line_data is valid (to ICache memory_ready)
- line_data  out  LINE_WORDS*WORD  assembled line; word i at bits [i*WORD +: WORD]
- ar_valid  out  1  read-address valid
- ar_ready  in  1  read-address accepted
- ar_addr  out  WORD  line-aligned burst address
- ar_len  out  8  burst length minus one, constant LINE_WORDS-1
- ar_size  out  3  constant 3'b010 (4 bytes)
- ar_burst  out  2  constant 2'b01 (INCR)
- r_valid  in  1  read-data valid
- r_ready  out  1  read-data accept
- r_data  in  WORD  read beat
- r_last  in  1  last beat of the burst
- err  out  1  sticky protocol-mismatch flag

Behaviour:
- Reset (rst==0 at a clock edge):
  - state=IDLE; ar_valid=0, r_ready=0, req_ready=0, err=0.
  - ar_addr=0, line_data=0, beat counter=0.
- Constant outputs: ar_len, ar_size and ar_burst are constants, driven regardless of state.
- IDLE:
  - On req_valid=1, latch ar_addr = {req_addr[WORD-1:OFFSET_W], OFFSET_W'b0}.
  - Clear the beat counter and go to ADDR. The request is taken on the same edge it is seen.
- ADDR:
  - ar_valid=1; ar_addr stays stable until the handshake completes.
  - On ar_valid&ar_ready, go to DATA.
  - ar_ready may stay low indefinitely; the block holds in ADDR.
- DATA:
  - r_ready=1. Each beat with r_valid&r_ready writes r_data into line word[cnt], then cnt++.
  - Word order is ascending from offset 0, with no critical-word-first.
  - On the beat where cnt==LINE_WORDS-1, go to DONE. This happens regardless of r_last.
  - If r_last on that final beat is 0, set err=1.
  - If r_last=1 on any earlier beat, set err=1 and keep collecting until LINE_WORDS beats are received.
  - Gaps with r_valid=0 simply stall.
- DONE:
  - req_ready=1 for exactly one cycle, then go to IDLE.
  - The ICache leaves LOAD on this cycle, so req_valid seen in the following IDLE cycle is a new request.
- Latency (zero-wait memory):
  - Request edge to ar_valid: 1 cycle.
  - Last beat to req_ready: 1 cycle.
  - Minimum request-to-ready: LINE_WORDS+2 cycles.
- line_data hold: stable from the req_ready cycle until the next accepted request.
  - Registers are written only in DATA.
- Dropped request: if req_valid falls mid-refill, the burst still completes and the line is captured.
  - req_ready is suppressed in DONE if req_valid==0.
- Reset mid-burst: the block returns to IDLE immediately with all handshakes deasserted.
  - Outstanding beats are not drained; the memory side is reset by the same system reset.
- err:
  - Sticky; cleared only by reset.
  - Never blocks operation.
- Simultaneous events:
  - ar_ready may arrive in the same cycle ar_valid rises; the transfer completes that edge.
  - r_valid during ADDR is ignored because r_ready=0.

Decomposition:
- Shared header CPU_Parameter.vh carries:
  - WORD and CACHE line geometry (LINE_WORDS, OFFSET_W)
  - the AXI size/burst encodings
  - the state encodings IDLE=0, ADDR=1, DATA=2, DONE=3
- Single module, no sub-module.
  - The line buffer is a LINE_WORDS-entry register array written by the decoded beat counter.

Test Plan:
- Basic refill: req_addr=0x1C00_0014, ar_ready and r_valid always 1, r_data 0xA0..0xA3, r_last on beat 3 -> ar_addr=0x1C00_0010, ar_len=3; req_ready pulses at cycle 6 after request; line_data={0xA3,0xA2,0xA1,0xA0}; err=0.
- Backpressure: ar_ready low 5 cycles, r_valid gaps (1,0,0,1,1,0,1) -> ar_addr stable throughout ADDR; words land in order; exactly one req_ready pulse.
- Protocol error: r_last=1 on beat 1 -> err=1; refill still completes after 4 beats. Then r_last=0 on a final beat of the next refill -> err stays 1.
- Back-to-back misses: req_valid reasserted in the cycle after req_ready with addr 0x0000_0040 -> new burst to 0x40; previous line_data held until that request is taken.
- Reset mid-DATA: rst=0 after 2 beats -> next cycle ar_valid=0, r_ready=0, req_ready=0, line_data=0, err=0. A fresh request afterwards refills correctly.
- Dropped request: req_valid falls during DATA -> burst finishes; no req_ready pulse; block returns to IDLE.
